// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin sharing of one single-port, level-sensitive memory
// between an instruction-fetch port (read-only) and a load/store data port.
module memory_arbiter #(
  parameter int ADDRESS_WIDTH = 15,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fetch_request,
  input  logic [ADDRESS_WIDTH:0] fetch_address,
  output logic                   fetch_ready,
  output logic [DATA_WIDTH:0]    fetch_data,
  input  logic                   data_request,
  input  logic                   data_write,
  input  logic [ADDRESS_WIDTH:0] data_address,
  input  logic [DATA_WIDTH:0]    data_in,
  output logic                   data_ready,
  output logic [DATA_WIDTH:0]    data_out,
  output logic                   busy,
  output logic [ADDRESS_WIDTH:0] mem_address,
  output logic                   mem_write,
  output logic                   mem_read,
  output logic [DATA_WIDTH:0]    mem_in,
  input  logic [DATA_WIDTH:0]    mem_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  state_t                 r_state, w_state;
  logic                   r_last_grant, w_last_grant;
  logic                   r_winner, w_winner;
  logic                   r_write, w_write;
  logic                   w_pick_data;
  logic                   r_fetch_ready, w_fetch_ready;
  logic                   r_data_ready, w_data_ready;
  logic [DATA_WIDTH:0]    r_fetch_data, w_fetch_data;
  logic [DATA_WIDTH:0]    r_data_out, w_data_out;
  logic                   r_busy, w_busy;
  logic [ADDRESS_WIDTH:0] r_mem_address, w_mem_address;
  logic                   r_mem_write, w_mem_write;
  logic                   r_mem_read, w_mem_read;
  logic [DATA_WIDTH:0]    r_mem_in, w_mem_in;

  // State and every output are registered; mem_address/mem_in are loaded at the grant
  // so they are already stable during SETUP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_last_grant  <= GRANT_DATA;
      r_winner      <= GRANT_FETCH;
      r_write       <= 1'b0;
      r_fetch_ready <= 1'b0;
      r_data_ready  <= 1'b0;
      r_fetch_data  <= {(DATA_WIDTH+1){1'b0}};
      r_data_out    <= {(DATA_WIDTH+1){1'b0}};
      r_busy        <= 1'b0;
      r_mem_address <= {(ADDRESS_WIDTH+1){1'b0}};
      r_mem_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_in      <= {(DATA_WIDTH+1){1'b0}};
    end else begin
      r_state       <= w_state;
      r_last_grant  <= w_last_grant;
      r_winner      <= w_winner;
      r_write       <= w_write;
      r_fetch_ready <= w_fetch_ready;
      r_data_ready  <= w_data_ready;
      r_fetch_data  <= w_fetch_data;
      r_data_out    <= w_data_out;
      r_busy        <= w_busy;
      r_mem_address <= w_mem_address;
      r_mem_write   <= w_mem_write;
      r_mem_read    <= w_mem_read;
      r_mem_in      <= w_mem_in;
    end
  end

  // Next-state and next-output logic; strobes and ready pulses default low.
  always_comb begin
    w_state       = r_state;
    w_last_grant  = r_last_grant;
    w_winner      = r_winner;
    w_write       = r_write;
    w_pick_data   = 1'b0;
    w_fetch_ready = 1'b0;
    w_data_ready  = 1'b0;
    w_fetch_data  = r_fetch_data;
    w_data_out    = r_data_out;
    w_mem_address = r_mem_address;
    w_mem_write   = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_in      = r_mem_in;
    case (r_state)
      ST_IDLE: begin
        if (fetch_request || data_request) begin
          // On a tie the port that did not win last time gets the grant.
          if (fetch_request && data_request) begin
            w_pick_data = ~r_last_grant;
          end else begin
            w_pick_data = data_request;
          end
          w_winner     = w_pick_data;
          w_last_grant = w_pick_data;
          if (w_pick_data) begin
            w_mem_address = data_address;
            w_write       = data_write;
            w_mem_in      = data_in;
          end else begin
            w_mem_address = fetch_address;
            w_write       = 1'b0;
          end
          w_state = ST_SETUP;
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_SETUP: begin
        w_mem_read  = ~r_write;
        w_mem_write = r_write;
        w_state     = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!r_write) begin
          if (r_winner == GRANT_DATA) begin
            w_data_out = mem_out;
          end else begin
            w_fetch_data = mem_out;
          end
        end else begin
          w_data_out = r_data_out;
        end
        w_fetch_ready = (r_winner == GRANT_FETCH);
        w_data_ready  = (r_winner == GRANT_DATA);
        w_state       = ST_DONE;
      end
      ST_DONE: begin
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
    w_busy = (w_state != ST_IDLE);
  end

  assign fetch_ready = r_fetch_ready;
  assign fetch_data  = r_fetch_data;
  assign data_ready  = r_data_ready;
  assign data_out    = r_data_out;
  assign busy        = r_busy;
  assign mem_address = r_mem_address;
  assign mem_write   = r_mem_write;
  assign mem_read    = r_mem_read;
  assign mem_in      = r_mem_in;

endmodule
